lab9_soc_nios2_qsys_0_oci_dct_packer: RTL and testbench

Packs 2-bit data-capture-trace (DCT) codes from the Nios II OCI trace logic into 30-bit words of up to 15 codes. It is the stage directly upstream of the OCI test bench. It drives the `dct_buffer`/`dct_count` pair that the test bench observes, and it hands completed words to the trace FIFO over a valid/ready handshake. Double buffering lets accumulation continue while the output is stalled.

---
 rtl/lab9_soc_oci_trace_pkg.sv | 31 +++
 rtl/lab9_soc_nios2_qsys_0_oci_dct_outreg.sv | 71 +++++++
 rtl/lab9_soc_nios2_qsys_0_oci_dct_packer.sv | 89 ++++++++
 tb/tb_lab9_soc_nios2_qsys_0_oci_dct_packer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lab9_soc_oci_trace_pkg.sv
// Shared constants and types for the OCI data-capture-trace packer.
// Widths are fixed by the OCI trace word format.
package lab9_soc_oci_trace_pkg;

    localparam int unsigned DCT_CODE_W = 2;
    localparam int unsigned DCT_SLOTS  = 15;
    localparam int unsigned DCT_BUF_W  = 30;
    localparam int unsigned DCT_CNT_W  = 4;

    typedef enum logic {
        StEmpty,
        StFull
    } out_state_e;

    // Writes one code into slot idx of a packed buffer, leaving other slots untouched.
    function automatic logic [DCT_BUF_W-1:0] dct_slot_insert(
        input logic [DCT_BUF_W-1:0]  buf_in,
        input logic [DCT_CNT_W-1:0]  idx,
        input logic [DCT_CODE_W-1:0] code
    );
        logic [DCT_BUF_W-1:0] buf_out;
        buf_out = buf_in;
        for (int k = 0; k < int'(DCT_SLOTS); k++) begin
            if (idx == DCT_CNT_W'(k)) begin
                buf_out[k*DCT_CODE_W +: DCT_CODE_W] = code;
            end
        end
        return buf_out;
    endfunction

endpackage

// File: rtl/lab9_soc_nios2_qsys_0_oci_dct_outreg.sv
// Output holding register for packed DCT words: valid/ready handshake and
// a running count of words handed to the trace FIFO.
module lab9_soc_nios2_qsys_0_oci_dct_outreg
    import lab9_soc_oci_trace_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load_i,
    input  logic [DCT_BUF_W-1:0] load_data_i,
    input  logic [DCT_CNT_W-1:0] load_count_i,
    input  logic                 out_ready_i,
    output logic                 out_free_o,
    output logic                 out_valid_o,
    output logic [DCT_BUF_W-1:0] out_data_o,
    output logic [DCT_CNT_W-1:0] out_count_o,
    output logic [15:0]          word_count_o
);

    out_state_e           state_q, state_d;
    logic [DCT_BUF_W-1:0] data_q, data_d;
    logic [DCT_CNT_W-1:0] count_q, count_d;
    logic [15:0]          word_q, word_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        word_d  = word_q;
        unique case (state_q)
            StEmpty: begin
                if (load_i) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (load_i) begin
                    state_d = StFull;
                end else if (out_ready_i) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (load_i) begin
            data_d  = load_data_i;
            count_d = load_count_i;
            word_d  = word_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StEmpty;
            data_q  <= '0;
            count_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            word_q  <= word_d;
        end
    end

    assign out_valid_o  = (state_q == StFull);
    assign out_free_o   = (state_q == StEmpty) || out_ready_i;
    assign out_data_o   = data_q;
    assign out_count_o  = count_q;
    assign word_count_o = word_q;

endmodule

// File: rtl/lab9_soc_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit DCT codes into 30-bit words of up to 15 codes, double buffered
// against a stalled output so accumulation can continue.
module lab9_soc_nios2_qsys_0_oci_dct_packer
    import lab9_soc_oci_trace_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  trc_on,
    input  logic                  item_valid,
    input  logic [DCT_CODE_W-1:0] item_code,
    output logic                  item_ready,
    input  logic                  flush,
    output logic [DCT_BUF_W-1:0]  dct_buffer,
    output logic [DCT_CNT_W-1:0]  dct_count,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DCT_BUF_W-1:0]  out_data,
    output logic [DCT_CNT_W-1:0]  out_count,
    output logic [15:0]           word_count
);

    localparam logic [DCT_CNT_W-1:0] CntFull = DCT_CNT_W'(DCT_SLOTS);

    logic [DCT_BUF_W-1:0] buf_q, buf_d;
    logic [DCT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic                 out_free;
    logic                 accept;
    logic                 xfer;

    assign item_ready = trc_on && ((cnt_q != CntFull) || out_free);
    assign accept     = item_valid && item_ready;
    assign xfer       = ((cnt_q == CntFull) || (pend_q && (cnt_q != '0))) && out_free;

    always_comb begin
        buf_d  = buf_q;
        cnt_d  = cnt_q;
        pend_d = pend_q;

        if (xfer) begin
            // A code accepted on the transfer cycle starts the fresh buffer.
            buf_d = '0;
            cnt_d = '0;
            if (accept) begin
                buf_d = dct_slot_insert('0, '0, item_code);
                cnt_d = DCT_CNT_W'(1);
            end
        end else if (accept) begin
            buf_d = dct_slot_insert(buf_q, cnt_q, item_code);
            cnt_d = cnt_q + DCT_CNT_W'(1);
        end

        if (flush) begin
            pend_d = 1'b1;
        end else if (xfer || ((cnt_q == '0) && !accept)) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_q  <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;

    lab9_soc_nios2_qsys_0_oci_dct_outreg u_outreg (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_i       (xfer),
        .load_data_i  (buf_q),
        .load_count_i (cnt_q),
        .out_ready_i  (out_ready),
        .out_free_o   (out_free),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_count_o  (out_count),
        .word_count_o (word_count)
    );

endmodule

// File: tb/tb_lab9_soc_nios2_qsys_0_oci_dct_packer.sv
// Directed self-checking bench for the OCI DCT packer.
module tb_lab9_soc_nios2_qsys_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trc_on;
    logic        item_valid;
    logic [1:0]  item_code;
    logic        item_ready;
    logic        flush;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_data;
    logic [3:0]  out_count;
    logic [15:0] word_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lab9_soc_nios2_qsys_0_oci_dct_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .trc_on     (trc_on),
        .item_valid (item_valid),
        .item_code  (item_code),
        .item_ready (item_ready),
        .flush      (flush),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .word_count (word_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] code);
        item_valid = 1'b1;
        item_code  = code;
        tick();
        item_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    int acc;
    int rdy_low;

    initial begin
        reset_n    = 1'b0;
        trc_on     = 1'b0;
        item_valid = 1'b0;
        item_code  = 2'b00;
        flush      = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        check("rst_buf",   32'(dct_buffer), 32'h0);
        check("rst_cnt",   32'(dct_count),  32'h0);
        check("rst_valid", 32'(out_valid),  32'h0);
        check("rst_data",  32'(out_data),   32'h0);
        check("rst_ocnt",  32'(out_count),  32'h0);
        check("rst_words", 32'(word_count), 32'h0);
        check("rst_ready", 32'(item_ready), 32'h0);

        // Full word of 15 x 2'b01
        reset_n   = 1'b1;
        trc_on    = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) send(2'b01);
        check("t1_cnt15", 32'(dct_count),  32'd15);
        check("t1_buf",   32'(dct_buffer), 32'h15555555);
        check("t1_nv",    32'(out_valid),  32'h0);
        tick();
        check("t1_valid", 32'(out_valid),  32'h1);
        check("t1_data",  32'(out_data),   32'h15555555);
        check("t1_ocnt",  32'(out_count),  32'd15);
        check("t1_words", 32'(word_count), 32'd1);
        check("t1_cnt0",  32'(dct_count),  32'd0);
        tick();
        check("t1_drop",  32'(out_valid),  32'h0);

        // Partial flush of codes 3,2,1
        send(2'b11);
        send(2'b10);
        send(2'b01);
        pulse_flush();
        check("t2_nv_yet", 32'(out_valid),  32'h0);
        tick();
        check("t2_valid",  32'(out_valid),  32'h1);
        check("t2_data",   32'(out_data),   32'h0000001B);
        check("t2_ocnt",   32'(out_count),  32'd3);
        check("t2_words",  32'(word_count), 32'd2);
        tick();
        pulse_flush();
        tick();
        tick();
        check("t2_empty_flush", 32'(out_valid),  32'h0);
        check("t2_words_same",  32'(word_count), 32'd2);

        // Backpressure: 2'b10 offered continuously with the output stalled
        out_ready  = 1'b0;
        item_code  = 2'b10;
        item_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            if (item_ready) acc++;
            tick();
        end
        check("t3_accepted", 32'(acc),        32'd30);
        check("t3_ready_lo", 32'(item_ready), 32'h0);
        check("t3_cnt",      32'(dct_count),  32'd15);
        check("t3_valid",    32'(out_valid),  32'h1);
        check("t3_data1",    32'(out_data),   32'h2AAAAAAA);
        check("t3_words",    32'(word_count), 32'd3);
        out_ready = 1'b1;
        #1;
        check("t3_ready_hi", 32'(item_ready), 32'h1);
        tick();
        item_valid = 1'b0;
        check("t3_valid2",   32'(out_valid),  32'h1);
        check("t3_data2",    32'(out_data),   32'h2AAAAAAA);
        check("t3_ocnt2",    32'(out_count),  32'd15);
        check("t3_words2",   32'(word_count), 32'd4);
        check("t3_slot0",    32'(dct_count),  32'd1);
        check("t3_slot0buf", 32'(dct_buffer), 32'h2);
        tick();
        check("t3_drop",     32'(out_valid),  32'h0);

        // Flush coincident with a code at dct_count == 4
        send(2'b00);
        send(2'b01);
        send(2'b10);
        check("t4_cnt4", 32'(dct_count), 32'd4);
        flush      = 1'b1;
        item_valid = 1'b1;
        item_code  = 2'b11;
        tick();
        flush      = 1'b0;
        item_valid = 1'b0;
        check("t4_cnt5", 32'(dct_count), 32'd5);
        tick();
        check("t4_valid", 32'(out_valid),     32'h1);
        check("t4_ocnt",  32'(out_count),     32'd5);
        check("t4_data",  32'(out_data),      32'h392);
        check("t4_slot4", 32'(out_data[9:8]), 32'h3);
        check("t4_words", 32'(word_count),    32'd5);
        tick();

        // Sustained full-rate input with out_ready high
        rdy_low = 0;
        item_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            item_code = 2'(i);
            if (!item_ready) rdy_low++;
            tick();
        end
        item_valid = 1'b0;
        tick();
        check("tp_ready_lo", 32'(rdy_low),    32'd0);
        check("tp_words",    32'(word_count), 32'd8);
        check("tp_cnt",      32'(dct_count),  32'd0);
        tick();

        // Reset mid-word
        for (int i = 0; i < 7; i++) send(2'b11);
        check("t5_cnt7", 32'(dct_count), 32'd7);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t5_buf",   32'(dct_buffer), 32'h0);
        check("t5_cnt",   32'(dct_count),  32'h0);
        check("t5_valid", 32'(out_valid),  32'h0);
        check("t5_data",  32'(out_data),   32'h0);
        check("t5_ocnt",  32'(out_count),  32'h0);
        check("t5_words", 32'(word_count), 32'h0);
        pulse_flush();
        tick();
        tick();
        check("t5_noemit", 32'(out_valid),  32'h0);
        check("t5_words0", 32'(word_count), 32'h0);

        // Trace gated: acceptance blocked, flush still emits
        send(2'b01);
        send(2'b11);
        trc_on     = 1'b0;
        item_valid = 1'b1;
        item_code  = 2'b10;
        #1;
        check("t6_ready", 32'(item_ready), 32'h0);
        tick();
        check("t6_cnt", 32'(dct_count), 32'd2);
        pulse_flush();
        tick();
        item_valid = 1'b0;
        check("t6_valid", 32'(out_valid),  32'h1);
        check("t6_data",  32'(out_data),   32'hD);
        check("t6_ocnt",  32'(out_count),  32'd2);
        check("t6_words", 32'(word_count), 32'd1);
        check("t6_cnt0",  32'(dct_count),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
